// File: rtl/axi_dma_stream_writer.sv
// rtl/axi_dma_stream_writer.sv - write-side DMA sequencer splitting a 64-bit beat stream into AXI4 INCR bursts
// One burst is outstanding at a time. Bursts never cross a 4 KiB page.
module axi_dma_stream_writer #(
  parameter int         ID_WIDTH  = 8,
  parameter int         AXI_ID    = 0,
  parameter int         MAX_BURST = 16,
  parameter logic [3:0] AW_CACHE  = 4'b0011
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [63:0]         cmd_addr,
  input  logic [31:0]         cmd_beats,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [63:0]         s_data,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [ID_WIDTH-1:0] m_axi_awid,
  output logic [63:0]         m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [63:0]         m_axi_wdata,
  output logic [7:0]          m_axi_wstrb,
  output logic                m_axi_wlast,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic [ID_WIDTH-1:0] m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t      state, state_nxt;
  logic [63:0] addr, addr_nxt;
  logic [31:0] rem, rem_nxt;
  logic [8:0]  burst;
  logic [7:0]  beat_cnt;
  logic        done_q;
  logic        err_q;
  logic        cmd_fire;
  logic        w_fire;
  logic        load_burst;
  logic        unused_ok;

  // Beats in the next burst: limited by remaining work, MAX_BURST and the room left in the 4 KiB page.
  function automatic logic [8:0] burst_beats(input logic [63:0] a, input logic [31:0] r);
    logic [31:0] room;
    logic [31:0] n;
    room = 32'd512 - {23'd0, a[11:3]};
    n    = r;
    if (n > 32'(MAX_BURST)) n = 32'(MAX_BURST);
    if (n > room) n = room;
    return 9'(n);
  endfunction

  assign cmd_ready = reset && (state == S_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign w_fire    = m_axi_wvalid && m_axi_wready;

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    rem_nxt    = rem;
    load_burst = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          addr_nxt = {cmd_addr[63:3], 3'b000};
          rem_nxt  = cmd_beats;
          if (cmd_beats != 32'd0) begin
            state_nxt  = S_AW;
            load_burst = 1'b1;
          end
        end
      end
      S_AW: begin
        if (m_axi_awready) state_nxt = S_W;
      end
      S_W: begin
        if (w_fire && m_axi_wlast) state_nxt = S_B;
      end
      S_B: begin
        if (m_axi_bvalid) begin
          addr_nxt = addr + {52'd0, burst, 3'b000};
          rem_nxt  = rem - {23'd0, burst};
          if (rem_nxt == 32'd0) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt  = S_AW;
            load_burst = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      addr     <= 64'd0;
      rem      <= 32'd0;
      burst    <= 9'd0;
      beat_cnt <= 8'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      rem    <= rem_nxt;
      done_q <= 1'b0;
      if (load_burst) burst <= burst_beats(addr_nxt, rem_nxt);
      if (state == S_AW) beat_cnt <= 8'd0;
      else if (w_fire)   beat_cnt <= beat_cnt + 8'd1;
      if (cmd_fire) begin
        err_q <= 1'b0;
        if (cmd_beats == 32'd0) done_q <= 1'b1;
      end
      if ((state == S_B) && m_axi_bvalid) begin
        if (m_axi_bresp != 2'b00) err_q <= 1'b1;
        if (rem_nxt == 32'd0)     done_q <= 1'b1;
      end
    end
  end

  assign m_axi_awvalid = (state == S_AW);
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = 8'(burst - 9'd1);
  assign m_axi_awsize  = 3'd3;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AW_CACHE;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;

  // W is a straight pass-through of the stream; nothing is buffered here.
  assign m_axi_wvalid  = (state == S_W) && s_valid;
  assign s_ready       = (state == S_W) && m_axi_wready;
  assign m_axi_wdata   = s_data;
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_wlast   = (state == S_W) && (beat_cnt == m_axi_awlen);

  assign m_axi_bready  = (state == S_B);
  assign busy          = (state != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;

  assign unused_ok = &{1'b0, m_axi_bid, cmd_addr[2:0]};

endmodule

// File: tb/tb_axi_dma_stream_writer.sv
// tb/tb_axi_dma_stream_writer.sv - scoreboard bench for axi_dma_stream_writer
module tb_axi_dma_stream_writer;

  localparam int ID_WIDTH  = 8;
  localparam int MAX_BURST = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [63:0]         cmd_addr;
  logic [31:0]         cmd_beats;
  logic                s_valid;
  logic                s_ready;
  logic [63:0]         s_data;
  logic                m_axi_awvalid;
  logic                m_axi_awready;
  logic [ID_WIDTH-1:0] m_axi_awid;
  logic [63:0]         m_axi_awaddr;
  logic [7:0]          m_axi_awlen;
  logic [2:0]          m_axi_awsize;
  logic [1:0]          m_axi_awburst;
  logic                m_axi_awlock;
  logic [3:0]          m_axi_awcache;
  logic [2:0]          m_axi_awprot;
  logic [3:0]          m_axi_awqos;
  logic                m_axi_wvalid;
  logic                m_axi_wready;
  logic [63:0]         m_axi_wdata;
  logic [7:0]          m_axi_wstrb;
  logic                m_axi_wlast;
  logic                m_axi_bvalid;
  logic                m_axi_bready;
  logic [ID_WIDTH-1:0] m_axi_bid;
  logic [1:0]          m_axi_bresp;
  logic                busy;
  logic                done;
  logic                err;

  axi_dma_stream_writer #(
    .ID_WIDTH(ID_WIDTH), .AXI_ID(0), .MAX_BURST(MAX_BURST), .AW_CACHE(4'b0011)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awid(m_axi_awid),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bid(m_axi_bid),
    .m_axi_bresp(m_axi_bresp),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_aw_addr[$];
  logic [8:0]  exp_aw_len[$];
  logic [63:0] exp_w_data[$];
  logic        exp_w_last[$];
  logic [63:0] src_q[$];
  logic [1:0]  bresp_q[$];

  int   aw_delay  = 0;
  bit   w_toggle  = 1'b0;
  bit   gaps      = 1'b0;
  bit   w_hs      = 1'b0;
  int   done_cnt  = 0;
  int   aw_cycles = 0;
  int   w_total   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // AXI slave: awready after aw_delay cycles, optional toggling wready, one B per burst.
  initial begin : slave
    int aw_cnt;
    aw_cnt = 0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_bid     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_axi_awvalid) begin
        m_axi_awready = (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        m_axi_awready = 1'b0;
        aw_cnt = 0;
      end
      m_axi_wready = w_toggle ? ~m_axi_wready : 1'b1;
      if (m_axi_bready && !m_axi_bvalid) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
      end else if (!m_axi_bready) begin
        m_axi_bvalid = 1'b0;
      end
    end
  end

  // Stream source: holds valid/data until accepted, optional random gaps between beats.
  initial begin : source
    s_valid = 1'b0;
    s_data  = 64'd0;
    forever begin
      @(posedge clk);
      if (w_hs && (src_q.size() > 0)) void'(src_q.pop_front());
      #1;
      if (s_valid && !w_hs && (src_q.size() > 0)) begin
        s_data = src_q[0];
      end else if ((src_q.size() > 0) && (!gaps || ($urandom_range(0, 2) != 0))) begin
        s_valid = 1'b1;
        s_data  = src_q[0];
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expectations on AW and W handshakes, checks AW stability while stalled.
  logic        aw_wait = 1'b0;
  logic [63:0] aw_hold_addr;
  logic [7:0]  aw_hold_len;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (m_axi_awvalid) begin
      aw_cycles++;
      if (aw_wait) begin
        check("awaddr stable", m_axi_awaddr, aw_hold_addr);
        check("awlen stable", 64'(m_axi_awlen), 64'(aw_hold_len));
      end
      if (m_axi_awready) begin
        aw_wait = 1'b0;
        check("awaddr", m_axi_awaddr, (exp_aw_addr.size() > 0) ? exp_aw_addr.pop_front() : 64'hx);
        check("awlen", 64'(m_axi_awlen), (exp_aw_len.size() > 0) ? 64'(exp_aw_len.pop_front()) : 64'hx);
      end else begin
        aw_wait      = 1'b1;
        aw_hold_addr = m_axi_awaddr;
        aw_hold_len  = m_axi_awlen;
      end
    end else begin
      aw_wait = 1'b0;
    end
    w_hs = m_axi_wvalid && m_axi_wready;
    if (w_hs) begin
      w_total++;
      check("s_ready on W beat", 64'(s_ready), 64'd1);
      check("wdata", m_axi_wdata, (exp_w_data.size() > 0) ? exp_w_data.pop_front() : 64'hx);
      check("wlast", 64'(m_axi_wlast), (exp_w_last.size() > 0) ? 64'(exp_w_last.pop_front()) : 64'hx);
    end
  end

  task automatic send_cmd(input logic [63:0] addr, input logic [31:0] beats);
    logic [63:0] a;
    logic [31:0] r;
    logic [31:0] n;
    logic [31:0] room;
    logic [63:0] d;
    int t;
    a = addr & ~64'h7;
    r = beats;
    while (r != 32'd0) begin
      room = (32'd4096 - {20'd0, a[11:0]}) / 32'd8;
      n = r;
      if (n > 32'(MAX_BURST)) n = 32'(MAX_BURST);
      if (n > room) n = room;
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(9'(n - 32'd1));
      for (int i = 0; i < int'(n); i++) begin
        d = {$urandom, $urandom};
        src_q.push_back(d);
        exp_w_data.push_back(d);
        exp_w_last.push_back(i == int'(n) - 1);
      end
      a = a + {n[28:0], 3'b000};
      r = r - n;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_beats = beats;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_ready && t < 100);
    check("cmd accepted", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    int start;
    t = 0;
    start = done_cnt;
    while (done_cnt == start && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check({tag, " done seen"}, 64'(done_cnt != start), 64'd1);
    repeat (5) @(posedge clk);
    check({tag, " done pulses"}, 64'(done_cnt - start), 64'd1);
    check({tag, " aw left"}, 64'(exp_aw_addr.size()), 64'd0);
    check({tag, " w left"}, 64'(exp_w_data.size()), 64'd0);
    @(negedge clk);
    check({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time %0t reached, limit 400000", $time);
    $fatal(1);
  end

  initial begin : main
    int start;
    int t;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 64'd0;
    cmd_beats = 32'd0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst awvalid", 64'(m_axi_awvalid), 64'd0);
    check("rst wvalid", 64'(m_axi_wvalid), 64'd0);
    check("rst bready", 64'(m_axi_bready), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst err", 64'(err), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("idle cmd_ready", 64'(cmd_ready), 64'd1);
    check("awsize", 64'(m_axi_awsize), 64'd3);
    check("awburst", 64'(m_axi_awburst), 64'd1);
    check("awcache", 64'(m_axi_awcache), 64'd3);
    check("awlock/prot/qos/id", 64'({m_axi_awlock, m_axi_awprot, m_axi_awqos, m_axi_awid}), 64'd0);
    check("wstrb", 64'(m_axi_wstrb), 64'hFF);

    // 1: three bursts, 16+16+8
    send_cmd(64'h8000_0000, 32'd40);
    @(negedge clk);
    check("t1 busy", 64'(busy), 64'd1);
    wait_done("t1");
    check("t1 err", 64'(err), 64'd0);

    // 2: page boundary split
    send_cmd(64'h8000_0FF0, 32'd4);
    wait_done("t2");

    // 3: zero beats
    start = aw_cycles;
    send_cmd(64'h1000, 32'd0);
    @(negedge clk);
    check("t3 done", 64'(done), 64'd1);
    check("t3 busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("t3 done drop", 64'(done), 64'd0);
    repeat (4) @(negedge clk);
    check("t3 no aw", 64'(aw_cycles - start), 64'd0);
    check("t3 busy after", 64'(busy), 64'd0);

    // 4: stalled AW, toggling wready, gappy stream
    aw_delay = 5;
    w_toggle = 1'b1;
    gaps     = 1'b1;
    send_cmd(64'h0000_0040, 32'd16);
    wait_done("t4");
    aw_delay = 0;
    w_toggle = 1'b0;
    gaps     = 1'b0;

    // 5: slave error on second burst only
    bresp_q.push_back(2'b00);
    bresp_q.push_back(2'b10);
    send_cmd(64'h9000_0000, 32'd32);
    wait_done("t5");
    check("t5 err", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    check("t5 err held", 64'(err), 64'd1);
    send_cmd(64'h5000, 32'd1);
    @(negedge clk);
    check("t5 err cleared", 64'(err), 64'd0);
    wait_done("t5b");

    // 6: reset in the middle of W
    start = w_total;
    send_cmd(64'h4000, 32'd16);
    t = 0;
    while ((w_total - start) < 5 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("t6 reached beat 5", 64'(w_total - start), 64'd5);
    #2 reset = 1'b0;
    #1;
    check("t6 awvalid", 64'(m_axi_awvalid), 64'd0);
    check("t6 wvalid", 64'(m_axi_wvalid), 64'd0);
    check("t6 bready", 64'(m_axi_bready), 64'd0);
    check("t6 busy", 64'(busy), 64'd0);
    exp_aw_addr.delete();
    exp_aw_len.delete();
    exp_w_data.delete();
    exp_w_last.delete();
    src_q.delete();
    bresp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    send_cmd(64'h2000, 32'd2);
    wait_done("t6");
    check("t6 err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
